// File: rtl/proc_pkg.sv
// Shared definitions for the processor run controller: FSM encoding and
// default timing parameters.
package proc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RST  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } run_state_t;

    // CPU reset hold length, in cycles (must be at least 1)
    localparam int          RESET_CYCLES_DEF = 2;
    // RUN cycles allowed before the watchdog declares a timeout
    localparam logic [15:0] WD_LIMIT_DEF     = 16'h00FF;

endpackage

// File: rtl/run_watchdog.sv
// RUN-cycle counter with watchdog. Counts enabled cycles (saturating) and
// flags the cycle that is the limit-th enabled cycle since the last clear.
module run_watchdog #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         resetl,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         expired
);

    logic [W:0] count_nxt;

    // Widened so the +1 cannot wrap when count is saturated.
    assign count_nxt = {1'b0, count} + (W+1)'(1);

    // This enabled cycle is the limit-th one once count+1 reaches limit.
    assign expired = enable && (count_nxt >= {1'b0, limit});

    // Cycle counter: clear wins, otherwise count up while enabled, hold at all-ones.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count_nxt[W-1:0];
        end
    end

endmodule

// File: rtl/proc_run_ctrl.sv
// Program run controller: resets the CPU at a chosen start PC, lets it run
// until it reaches the final PC or the watchdog fires, and records the result.
module proc_run_ctrl
    import proc_pkg::*;
#(
    parameter int          RESET_CYCLES = RESET_CYCLES_DEF,
    parameter logic [15:0] WD_LIMIT     = WD_LIMIT_DEF
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic        start,
    input  logic        clear_count,
    input  logic [63:0] prog_startpc,
    input  logic [63:0] prog_endpc,
    input  logic [63:0] expected,
    input  logic [63:0] currentpc,
    input  logic [63:0] MemtoRegOut,
    output logic        cpu_resetl,
    output logic [63:0] cpu_startpc,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [7:0]  pass_count,
    output logic [15:0] cycle_count
);

    run_state_t  state;
    logic [63:0] end_pc;
    logic [63:0] exp_val;
    logic [15:0] rst_cnt;
    logic        end_hit;
    logic        data_ok;
    logic        wd_clear;
    logic        wd_en;
    logic        wd_expired;

    // Comparators against the values latched at start.
    assign end_hit  = (currentpc >= end_pc);
    assign data_ok  = (MemtoRegOut == exp_val);
    assign wd_clear = (state == ST_IDLE) && start;
    assign wd_en    = (state == ST_RUN);

    run_watchdog #(.W(16)) u_wd (
        .CLK     (CLK),
        .resetl  (resetl),
        .clear   (wd_clear),
        .enable  (wd_en),
        .limit   (WD_LIMIT),
        .count   (cycle_count),
        .expired (wd_expired)
    );

    // Run sequencing FSM with registered CPU-control, status and result outputs.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state       <= ST_IDLE;
            cpu_resetl  <= 1'b1;
            cpu_startpc <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            end_pc      <= '0;
            exp_val     <= '0;
            rst_cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cpu_startpc <= prog_startpc;
                        end_pc      <= prog_endpc;
                        exp_val     <= expected;
                        pass        <= 1'b0;
                        timeout     <= 1'b0;
                        cpu_resetl  <= 1'b0;
                        busy        <= 1'b1;
                        rst_cnt     <= '0;
                        state       <= ST_RST;
                    end
                end
                ST_RST: begin
                    // cpu_resetl went low on entry; release after RESET_CYCLES cycles here.
                    if (rst_cnt >= 16'(RESET_CYCLES - 1)) begin
                        cpu_resetl <= 1'b1;
                        state      <= ST_RUN;
                    end else begin
                        rst_cnt <= rst_cnt + 16'd1;
                    end
                end
                ST_RUN: begin
                    // An endpc match outranks a watchdog expiry in the same cycle.
                    if (end_hit) begin
                        pass  <= data_ok;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else if (wd_expired) begin
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Passing-run tally: clear wins over the DONE-cycle increment; saturates at 255.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            pass_count <= '0;
        end else if (clear_count) begin
            pass_count <= '0;
        end else if ((state == ST_DONE) && pass && (pass_count != 8'hFF)) begin
            pass_count <= pass_count + 8'd1;
        end
    end

endmodule

// File: doc/proc_run_ctrl.md
PROC_RUN_CTRL -- requirements
Module: proc_run_ctrl

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 2: CPU reset hold length in cycles, minimum 1.
REQ-002 SHALL have parameter WD_LIMIT, default 16'h00FF: maximum RUN cycles before timeout.
REQ-003 SHALL have port CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetl, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: begins one program run when sampled high in IDLE.
REQ-006 SHALL have port clear_count, input, 1: zeroes pass_count.
REQ-007 SHALL have port prog_startpc, input, 64: program entry PC.
REQ-008 SHALL have port prog_endpc, input, 64: final-instruction PC.
REQ-009 SHALL have port expected, input, 64: expected MemtoRegOut at the final instruction.
REQ-010 SHALL have port currentpc, input, 64: the processor's current PC.
REQ-011 SHALL have port MemtoRegOut, input, 64: the processor's writeback value.
REQ-012 SHALL have port cpu_resetl, output, 1: drives the processor's resetl.
REQ-013 SHALL have port cpu_startpc, output, 64: drives the processor's startpc.
REQ-014 SHALL have port busy, output, 1: high in RST and RUN.
REQ-015 SHALL have port done, output, 1: one-cycle pulse at run completion.
REQ-016 SHALL have port pass, output, 1: result of the last run.
REQ-017 SHALL have port timeout, output, 1: the last run hit WD_LIMIT.
REQ-018 SHALL have port pass_count, output, 8: passing runs since reset or clear.
REQ-019 SHALL have port cycle_count, output, 16: RUN cycles in the current or last run.

Function
REQ-020 SHALL implement FSM states IDLE, RST, RUN and DONE.
REQ-021 IDLE with start=1 SHALL register cpu_startpc<=prog_startpc, latch prog_endpc and expected internally, clear pass, timeout and cycle_count, and go to RST.
REQ-022 SHALL drive cpu_resetl low for exactly RESET_CYCLES cycles in RST, then go to RUN; cpu_resetl SHALL be high in every other state.
REQ-023 In RUN, each cycle SHALL increment cycle_count, which saturates at 16'hFFFF.
REQ-024 In RUN, if currentpc >= latched endpc (unsigned), the block SHALL set pass<=(MemtoRegOut==latched expected) in that same cycle and go to DONE.
REQ-025 In RUN, if there is no endpc match and this is the WD_LIMIT-th RUN cycle, the block SHALL set timeout<=1 and pass<=0 and go to DONE.
REQ-026 If the endpc match and the watchdog limit occur in the same cycle, the endpc match SHALL win and timeout SHALL stay 0.
REQ-027 DONE SHALL assert done for one cycle, increment pass_count if pass=1 (saturating at 255), and return to IDLE.
REQ-028 start SHALL be ignored outside IDLE.
REQ-029 clear_count SHALL take priority over the DONE increment in the same cycle.
REQ-030 pass, timeout, cycle_count and cpu_startpc SHALL hold their values in IDLE until the next accepted start.
REQ-031 A start in the IDLE cycle directly after DONE SHALL be accepted.

Reset
REQ-032 resetl low SHALL force, asynchronously: state=IDLE, cpu_resetl=1, cpu_startpc=0, busy=0, done=0, pass=0, timeout=0, pass_count=0, cycle_count=0.
REQ-033 Reset asserted mid-run SHALL abandon the run without a done pulse and without changing pass_count.

Structure
REQ-034 FSM state encoding, the default WD_LIMIT and the default RESET_CYCLES SHALL live in the shared package proc_pkg.
REQ-035 The watchdog/cycle counter SHALL be a sub-module named run_watchdog (inputs: clear, enable, limit; outputs: count, expired).
REQ-036 The comparators and the pass/timeout result register SHALL be in the top module; there SHALL be no other sub-modules.

Verification
REQ-037 Test: start, startpc=0, endpc=0x30, expected=0xF, model reaches PC 0x30 with MemtoRegOut=0xF -> cpu_resetl low for 2 cycles, done pulse, pass=1, pass_count=1.
REQ-038 Test: startpc=0x30, endpc=0x34, expected=0x320000, MemtoRegOut=0 at 0x34 -> pass=0, timeout=0, pass_count unchanged.
REQ-039 Test: endpc=0x5C, model PC stuck at 0x3C -> timeout=1, pass=0, cycle_count=0x00FF, done on the following cycle.
REQ-040 Test: endpc match on the 255th RUN cycle -> timeout=0, pass follows the compare.
REQ-041 Test: resetl low during RUN -> all outputs at reset values immediately, no done pulse; start pulses during RUN are ignored.
REQ-042 Test: clear_count asserted in the DONE cycle of a passing run -> pass_count=0; 256 passing runs -> pass_count=255.
